execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline execute stage, directly upstream of the memory stage.
- Takes decoded operands and control from decode, computes a 24-bit ALU result, and registers result plus control into the memory stage inputs.
- Single-cycle ops: add, sub, and, or, xor, shl, shr.
- MUL is an iterative multi-cycle operation. The stage back-pressures decode with `stall` while MUL runs.

Parameters:
- `DATA_W`, 24, datapath width; must match the memory stage.
- `REG_AW`, 4, register index width.
- `MUL_RADIX_BITS`, 1, multiplier bits consumed per iteration; must divide `DATA_W`. `N = DATA_W / MUL_RADIX_BITS` iterations.

Ports:
- `clk`  in  1  stage clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  decode presents a valid instruction.
- `aluOp`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `operandA`  in  `DATA_W`  first ALU operand.
- `operandB`  in  `DATA_W`  second ALU operand / shift amount.
- `storeData`  in  `DATA_W`  data for store instructions.
- `memWe`, `writeRegFromAlu`, `regWe`  in  1 each  control bits passed to the memory stage.
- `regToWrite`  in  `REG_AW`  destination register.
- `flush`  in  1  synchronous kill of the stage contents.
- `stall`  out  1  combinational; decode must hold all inputs while high.
- `memWeOut`, `writeRegFromAluOut`, `regWeOut`  out  1 each  registered control.
- `resultOut`  out  `DATA_W`  registered ALU result / memory address.
- `dataToWriteOut`  out  `DATA_W`  registered store data.
- `regToWriteOut`  out  `REG_AW`  registered destination.
- `zeroOut`  out  1  registered flag: `resultOut == 0` for a valid instruction.

Behaviour:
- **Reset.** While `reset` = 0: all outputs 0, FSM in IDLE, multiplier registers 0. Reset asserted mid-MUL abandons the MUL with no output.
- **Bubble.** All registered outputs 0, including `zeroOut`. Loaded when `inValid` = 0, on `flush`, and while a MUL is in progress.
- **Single-cycle ops.** Result is registered at the next edge, giving 1-cycle latency. Controls and `storeData` are registered alongside it unchanged.
- **Arithmetic.**
  - ADD and SUB wrap modulo 2^`DATA_W`.
  - SHL and SHR are logical and use `operandB[4:0]`. An amount ≥ `DATA_W` gives 0.
  - MUL returns the low `DATA_W` bits of A*B (unsigned).
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE.** If `inValid` and `aluOp` = 111, `stall` = 1. At the edge, latch A, B and controls, clear the iteration counter, go to BUSY, and output a bubble. Otherwise handle the op as single-cycle with `stall` = 0.
  - **BUSY.** `stall` = 1. Each edge performs one shift-add step of `MUL_RADIX_BITS` bits. After step N, go to DONE. Output a bubble every cycle.
  - **DONE.** `stall` = 0, so decode may advance past the held MUL. At the edge, load the product with the latched controls into the output registers and go to IDLE.
  - Total MUL occupancy is N+2 cycles. The product is visible N+2 edges after the edge at which the MUL was first presented.
  - In DONE, the stage ignores its inputs because decode is still presenting the held MUL. The next instruction is accepted in the following cycle.
- **Flush.** Has priority over everything: bubble loaded, FSM forced to IDLE, any MUL dropped, `stall` = 0 in that cycle.
- **Input changes.** Operands changing during BUSY have no effect; operands are latched at start.
- **Back-to-back MULs.** The second MUL starts only from IDLE, i.e. one cycle after DONE.

Optional Feature:
- Macro `EXEC_MUL_EN`.
- **Defined:** iterative MUL and FSM as above.
- **Undefined:**
  - No multiplier or FSM logic.
  - `stall` is tied 0.
  - `aluOp` 111 completes in one cycle with `resultOut` = 0 and `zeroOut` = 1. Its controls pass through normally.

Test Plan:
- **Reset and ADD.** Reset low then high; ADD A=5, B=18, `regWe`=1, `writeRegFromAlu`=1, `regToWrite`=3 → next edge `resultOut`=23, `regWeOut`=1, `regToWriteOut`=3, `zeroOut`=0. All outputs were 0 during reset.
- **Store pass-through and wrap.**
  - Store: `memWe`=1, ADD A=100, B=23, `storeData`=70 → `resultOut`=123, `dataToWriteOut`=70, `memWeOut`=1.
  - SUB A=0, B=1 → `resultOut`=0xFFFFFF.
  - SHL by 30 → 0.
- **MUL.** A=555, B=3, `MUL_RADIX_BITS`=1 → `stall` high for 25 cycles (IDLE + 24 BUSY) and outputs bubble meanwhile. `resultOut`=1665 appears 26 edges after presentation.
- **MUL overflow and back-to-back.**
  - A=0x001000, B=0x001000 → `resultOut`=0.
  - Immediately following MUL A=7, B=6 → 42.
  - The second MUL begins one cycle after the first one's DONE.
- **Flush.** Flush in BUSY cycle 10 → `stall` drops that cycle, output stays bubble, next ADD 1+1 gives 2 one edge later.
- **Async reset mid-MUL.** `reset`=0 asynchronously during BUSY → outputs 0 immediately, `stall`=0. After release, ADD 2+2 gives 4 with no stale product.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: pipeline execute stage feeding the memory stage.
// Computes a DATA_W-bit ALU result from decoded operands and registers it,
// together with the pass-through control bits and store data, into the
// memory-stage inputs. Single-cycle ops: ADD, SUB, AND, OR, XOR, SHL, SHR.
//
// Build option EXEC_MUL_EN:
//   defined   - MUL (aluOp 3'b111) runs on an iterative shift-add multiplier
//               under an IDLE/BUSY/DONE FSM. stall back-pressures decode while
//               the multiply is in flight.
//   undefined - no multiplier or FSM. stall is tied low. MUL completes in one
//               cycle with result 0 (so zeroOut = 1) and normal controls.
module execute_stage #(
  parameter int DATA_W         = 24,
  parameter int REG_AW         = 4,
  parameter int MUL_RADIX_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic [2:0]        aluOp,
  input  logic [DATA_W-1:0] operandA,
  input  logic [DATA_W-1:0] operandB,
  input  logic [DATA_W-1:0] storeData,
  input  logic              memWe,
  input  logic              writeRegFromAlu,
  input  logic              regWe,
  input  logic [REG_AW-1:0] regToWrite,
  input  logic              flush,
  output logic              stall,
  output logic              memWeOut,
  output logic              writeRegFromAluOut,
  output logic              regWeOut,
  output logic [DATA_W-1:0] resultOut,
  output logic [DATA_W-1:0] dataToWriteOut,
  output logic [REG_AW-1:0] regToWriteOut,
  output logic              zeroOut
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [31:0] DATA_W_U = 32'(DATA_W);

  // A radix that does not divide the width would leave a partial final step.
  if ((DATA_W % MUL_RADIX_BITS) != 0) begin : g_radix_check
    $error("execute_stage: MUL_RADIX_BITS must divide DATA_W");
  end

  // Control fields that travel with an instruction to the memory stage.
  typedef struct packed {
    logic              mem_we;
    logic              wfa;
    logic              reg_we;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] store;
  } ctl_t;

  // Full contents of the stage output register. All-zero is a bubble.
  typedef struct packed {
    ctl_t              ctl;
    logic [DATA_W-1:0] result;
    logic              zero;
  } out_t;

  ctl_t              ctl_in;
  out_t              single_out;
  out_t              out_q;
  out_t              out_d;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        shamt;
  logic              shift_oob;

  assign ctl_in = '{mem_we: memWe, wfa: writeRegFromAlu, reg_we: regWe,
                    dst: regToWrite, store: storeData};

  // Shifts use only the low five bits of operandB; anything past the width clears.
  assign shamt     = operandB[4:0];
  assign shift_oob = (32'(shamt) >= DATA_W_U);

  // Single-cycle ALU; MUL is not produced here (FSM result or constant zero).
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it holding its old value -- that is what keeps latches out.
  always_comb begin
    alu_res = '0;
    case (aluOp)
      OP_ADD:  alu_res = operandA + operandB;
      OP_SUB:  alu_res = operandA - operandB;
      OP_AND:  alu_res = operandA & operandB;
      OP_OR:   alu_res = operandA | operandB;
      OP_XOR:  alu_res = operandA ^ operandB;
      OP_SHL:  alu_res = shift_oob ? '0 : (operandA << shamt);
      OP_SHR:  alu_res = shift_oob ? '0 : (operandA >> shamt);
      default: alu_res = '0;
    endcase
  end

  assign single_out = '{ctl: ctl_in, result: alu_res, zero: (alu_res == '0)};

  // Stage output register; reset and bubbles both load all zeros.
  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values no matter how the statements are ordered. The datapath
  // registers are reset as well because the outputs must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

`ifdef EXEC_MUL_EN

  localparam int              N         = DATA_W / MUL_RADIX_BITS;
  localparam int              CNT_W     = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q,   prod_d;
  logic [CNT_W-1:0]  iter_q,   iter_d;
  ctl_t              lat_q,    lat_d;
  logic [DATA_W-1:0] step_sum;

  // One shift-add step: add the shifted multiplicand for each set multiplier bit.
  // NOTE: blocking = is used here because step_sum accumulates across loop
  // iterations within a single evaluation; this is combinational, not state.
  always_comb begin
    step_sum = prod_q;
    for (int j = 0; j < MUL_RADIX_BITS; j++) begin
      if (mplier_q[j]) step_sum = step_sum + (mcand_q << j);
    end
  end

  // Decode holds the MUL while it starts and while it iterates; flush and reset release it.
  assign stall = reset & ~flush &
                 ((state_q == ST_BUSY) |
                  ((state_q == ST_IDLE) & inValid & (aluOp == OP_MUL)));

  // Next-state for the FSM, the multiplier and the output register.
  always_comb begin
    out_d    = '0;
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    iter_d   = iter_q;
    lat_d    = lat_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inValid && (aluOp == OP_MUL)) begin
            mcand_d  = operandA;
            mplier_d = operandB;
            prod_d   = '0;
            iter_d   = '0;
            lat_d    = ctl_in;
            state_d  = ST_BUSY;
          end else if (inValid) begin
            out_d = single_out;
          end
        end
        ST_BUSY: begin
          prod_d   = step_sum;
          mcand_d  = mcand_q << MUL_RADIX_BITS;
          mplier_d = mplier_q >> MUL_RADIX_BITS;
          iter_d   = iter_q + CNT_W'(1);
          if (iter_q == LAST_STEP) state_d = ST_DONE;
        end
        ST_DONE: begin
          // Inputs still show the held MUL here, so they are ignored.
          out_d   = '{ctl: lat_q, result: prod_q, zero: (prod_q == '0)};
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and multiplier registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      iter_q   <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      iter_q   <= iter_d;
      lat_q    <= lat_d;
    end
  end

`else

  assign stall = 1'b0;

  // Without the multiplier every valid op, MUL included, completes in one cycle.
  always_comb begin
    out_d = '0;
    if (!flush && inValid) out_d = single_out;
  end

`endif

  assign memWeOut           = out_q.ctl.mem_we;
  assign writeRegFromAluOut = out_q.ctl.wfa;
  assign regWeOut           = out_q.ctl.reg_we;
  assign regToWriteOut      = out_q.ctl.dst;
  assign dataToWriteOut     = out_q.ctl.store;
  assign resultOut          = out_q.result;
  assign zeroOut            = out_q.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed scenarios plus randomized traffic,
// checked against a plain-arithmetic reference model. Expectations follow
// the EXEC_MUL_EN build option the bench is compiled with.
module tb_execute_stage;

  localparam int DW = 24;
  localparam int AW = 4;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  // Cycles stall stays high for one MUL: the IDLE start cycle plus DW BUSY cycles.
  localparam int MUL_CYC = MUL_EN ? (DW + 1) : 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic [2:0]    aluOp;
  logic [DW-1:0] operandA;
  logic [DW-1:0] operandB;
  logic [DW-1:0] storeData;
  logic          memWe;
  logic          writeRegFromAlu;
  logic          regWe;
  logic [AW-1:0] regToWrite;
  logic          flush;
  logic          stall;
  logic          memWeOut;
  logic          writeRegFromAluOut;
  logic          regWeOut;
  logic [DW-1:0] resultOut;
  logic [DW-1:0] dataToWriteOut;
  logic [AW-1:0] regToWriteOut;
  logic          zeroOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                (clk),
    .reset              (reset),
    .inValid            (inValid),
    .aluOp              (aluOp),
    .operandA           (operandA),
    .operandB           (operandB),
    .storeData          (storeData),
    .memWe              (memWe),
    .writeRegFromAlu    (writeRegFromAlu),
    .regWe              (regWe),
    .regToWrite         (regToWrite),
    .flush              (flush),
    .stall              (stall),
    .memWeOut           (memWeOut),
    .writeRegFromAluOut (writeRegFromAluOut),
    .regWeOut           (regWeOut),
    .resultOut          (resultOut),
    .dataToWriteOut     (dataToWriteOut),
    .regToWriteOut      (regToWriteOut),
    .zeroOut            (zeroOut)
  );

  // All registered outputs as one vector: {ctl(3), result, data, dst, zero}.
  logic [55:0] dut_bus;
  assign dut_bus = {memWeOut, writeRegFromAluOut, regWeOut, resultOut,
                    dataToWriteOut, regToWriteOut, zeroOut};

  // Reference ALU written from the arithmetic rules, using wide integers.
  function automatic logic [DW-1:0] model_alu(input logic [2:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    longint unsigned m = 64'd1 << DW;
    longint unsigned x = 64'(a);
    longint unsigned y = 64'(b);
    longint unsigned r = 0;
    int sh = int'(b % 32);
    case (op)
      OP_ADD: r = (x + y) % m;
      OP_SUB: r = (x + m - y) % m;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: r = (sh >= DW) ? 0 : (x * (64'd1 << sh)) % m;
      OP_SHR: r = (sh >= DW) ? 0 : x / (64'd1 << sh);
      default: r = MUL_EN ? (x * y) % m : 0;
    endcase
    return r[DW-1:0];
  endfunction

  // Expected output vector for the instruction currently driven by the bench.
  function automatic logic [55:0] exp_now();
    logic [DW-1:0] r;
    if (!inValid) return '0;
    r = model_alu(aluOp, operandA, operandB);
    return {memWe, writeRegFromAlu, regWe, r, storeData, regToWrite, (r == '0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] sd, input logic mwe,
                       input logic wfa, input logic rwe, input logic [AW-1:0] rd);
    inValid = v; aluOp = op; operandA = a; operandB = b; storeData = sd;
    memWe = mwe; writeRegFromAlu = wfa; regWe = rwe; regToWrite = rd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b1, OP_MUL, 24'd5, 24'd6, 24'd7, 1'b1, 1'b1, 1'b1, 4'd9);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    repeat (3) tick();
    n_checks++;
    if (dut_bus !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_bus);
    end
    inValid = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_add();
    logic [55:0] e;
    drive(1'b1, OP_ADD, 24'd5, 24'd18, 24'd0, 1'b0, 1'b1, 1'b1, 4'd3);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL add_stall: got %b expected 0", stall);
    end
    tick();
    e = exp_now();
    n_checks++;
    if (dut_bus !== e) begin
      n_fail++; $display("FAIL add_bus: got %h expected %h", dut_bus, e);
    end
    n_checks++;
    if (resultOut !== 24'd23) begin
      n_fail++; $display("FAIL add_result: got %0d expected 23", resultOut);
    end
  endtask

  task automatic test_store_wrap();
    logic [2:0]    t_op [8] = '{OP_ADD, OP_SUB, OP_SHL, OP_SHL, OP_SHR, OP_SHR, OP_XOR, OP_AND};
    logic [DW-1:0] t_a  [8] = '{24'd100, 24'd0, 24'd1, 24'd1, 24'hFFFFFF, 24'hFFFFFF,
                                24'hA5A5A5, 24'h0F0F0F};
    logic [DW-1:0] t_b  [8] = '{24'd23, 24'd1, 24'd30, 24'd23, 24'd24, 24'd23,
                                24'hA5A5A5, 24'hF0F0F0};
    logic [DW-1:0] t_r  [8] = '{24'd123, 24'hFFFFFF, 24'd0, 24'h800000, 24'd0, 24'd1,
                                24'd0, 24'd0};
    logic [55:0] e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_op[i], t_a[i], t_b[i], 24'd70, 1'b1, 1'b0, 1'b0, 4'd7);
      tick();
      e = exp_now();
      n_checks++;
      if (dut_bus !== e) begin
        n_fail++; $display("FAIL store_wrap_bus[%0d]: got %h expected %h", i, dut_bus, e);
      end
      n_checks++;
      if (resultOut !== t_r[i] || zeroOut !== (t_r[i] == '0) ||
          dataToWriteOut !== 24'd70 || memWeOut !== 1'b1) begin
        n_fail++;
        $display("FAIL store_wrap_fields[%0d]: got res=%h zero=%b data=%0d we=%b expected res=%h data=70 we=1",
                 i, resultOut, zeroOut, dataToWriteOut, memWeOut, t_r[i]);
      end
    end
  endtask

  // One MUL from IDLE: stall profile, bubbles while busy, product on the final edge.
  task automatic test_mul_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] lit);
    logic [55:0]   e;
    logic [DW-1:0] want;
    drive(1'b1, OP_MUL, a, b, 24'h00ABCD, 1'b0, 1'b1, 1'b1, 4'd6);
    #1;
    for (int i = 0; i < MUL_CYC; i++) begin
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL mul_stall[%0d]: got %b expected 1", i, stall);
      end
      if (i > 0) begin
        n_checks++;
        if (dut_bus !== '0) begin
          n_fail++; $display("FAIL mul_bubble[%0d]: got %h expected 0", i, dut_bus);
        end
      end
      tick();
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL mul_done_stall: got %b expected 0", stall);
    end
    tick();
    e = exp_now();
    n_checks++;
    if (dut_bus !== e) begin
      n_fail++; $display("FAIL mul_bus: got %h expected %h", dut_bus, e);
    end
    want = MUL_EN ? lit : '0;
    n_checks++;
    if (resultOut !== want) begin
      n_fail++; $display("FAIL mul_result: got %0d expected %0d", resultOut, want);
    end
  endtask

  task automatic test_mul();
    test_mul_op(24'd555, 24'd3, 24'd1665);
  endtask

  task automatic test_back_to_back();
    test_mul_op(24'h001000, 24'h001000, 24'd0);
    test_mul_op(24'd7, 24'd6, 24'd42);
  endtask

  task automatic test_flush();
    logic [55:0] e;
    drive(1'b1, OP_MUL, 24'd9, 24'd9, 24'd0, 1'b0, 1'b1, 1'b1, 4'd2);
    #1;
    repeat (10) tick();
    n_checks++;
    if (stall !== MUL_EN) begin
      n_fail++; $display("FAIL flush_pre_stall: got %b expected %b", stall, MUL_EN);
    end
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b expected 0", stall);
    end
    tick();
    n_checks++;
    if (dut_bus !== '0) begin
      n_fail++; $display("FAIL flush_bubble: got %h expected 0", dut_bus);
    end
    flush = 1'b0;
    drive(1'b1, OP_ADD, 24'd1, 24'd1, 24'd0, 1'b0, 1'b1, 1'b1, 4'd5);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_add_stall: got %b expected 0", stall);
    end
    tick();
    e = exp_now();
    n_checks++;
    if (dut_bus !== e || resultOut !== 24'd2) begin
      n_fail++; $display("FAIL flush_add: got %h expected %h", dut_bus, e);
    end
    inValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (dut_bus !== '0) begin
        n_fail++; $display("FAIL flush_no_stale[%0d]: got %h expected 0", i, dut_bus);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [55:0] e;
    drive(1'b1, OP_ADD, 24'd9, 24'd9, 24'd33, 1'b1, 1'b1, 1'b1, 4'd4);
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dut_bus !== '0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL areset_clear: got %h stall=%b expected 0 stall=0", dut_bus, stall);
    end
    tick();
    reset = 1'b1;
    drive(1'b1, OP_MUL, 24'd555, 24'd3, 24'd0, 1'b0, 1'b1, 1'b1, 4'd8);
    #1;
    repeat (6) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dut_bus !== '0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL areset_mul: got %h stall=%b expected 0 stall=0", dut_bus, stall);
    end
    inValid = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b1, OP_ADD, 24'd2, 24'd2, 24'd0, 1'b0, 1'b1, 1'b1, 4'd1);
    tick();
    e = exp_now();
    n_checks++;
    if (dut_bus !== e || resultOut !== 24'd4) begin
      n_fail++; $display("FAIL areset_add: got %h expected %h", dut_bus, e);
    end
    inValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (dut_bus !== '0) begin
        n_fail++; $display("FAIL areset_no_stale[%0d]: got %h expected 0", i, dut_bus);
      end
    end
  endtask

  task automatic test_random();
    logic [55:0] e;
    logic        v;
    logic [2:0]  op;
    int          cyc;
    int          want_cyc;
    for (int n = 0; n < 60; n++) begin
      v  = ($urandom_range(0, 7) != 0);
      op = 3'($urandom_range(0, 7));
      drive(v, op, DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), AW'($urandom));
      if ($urandom_range(0, 3) == 0) operandA = DW'($urandom_range(0, 3));
      #1;
      cyc = 0;
      while (stall === 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      want_cyc = (v && op == OP_MUL) ? MUL_CYC : 0;
      n_checks++;
      if (cyc !== want_cyc) begin
        n_fail++; $display("FAIL rand_stall_cycles[%0d]: got %0d expected %0d", n, cyc, want_cyc);
      end
      tick();
      e = exp_now();
      n_checks++;
      if (dut_bus !== e) begin
        n_fail++; $display("FAIL rand_bus[%0d] op=%0d: got %h expected %h", n, op, dut_bus, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_store_wrap();
    test_mul();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
